// File: rtl/dac_sample_sched.sv
// rtl/dac_sample_sched.sv - stereo sample FIFO with programmable-rate DAC load strobe
// Two requesters push packed 16-bit words; each divider tick pops one word to DAC_D.
module dac_sample_sched #(
    parameter int DEPTH = 4,
    parameter int DIV_W = 12
) (
    input  logic                     XCK,
    input  logic                     RESETL,
    input  logic                     dsp_req,
    input  logic [15:0]              dsp_data,
    output logic                     dsp_ack,
    input  logic                     cpu_req,
    input  logic [15:0]              cpu_data,
    output logic                     cpu_ack,
    input  logic                     per_wr,
    input  logic [DIV_W-1:0]         per_data,
    input  logic                     enable,
    input  logic                     clr_urun,
    output logic                     DACWRL,
    output logic [15:0]              DAC_D,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [DIV_W-1:0] MIN_PER = DIV_W'(128);
    localparam logic [DIV_W-1:0] RST_PER = DIV_W'(512);

    logic [15:0]      mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      level;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] per_clamped;
    logic [15:0]      wdata;
    logic             push;
    logic             pop;
    logic             tick;

    assign fifo_full  = (level == (AW+1)'(DEPTH));
    assign fifo_empty = (level == '0);
    assign fifo_level = level;

    // DSP has fixed priority; the losing requester keeps its request up.
    assign dsp_ack = dsp_req & ~fifo_full;
    assign cpu_ack = cpu_req & ~dsp_req & ~fifo_full;
    assign push    = dsp_ack | cpu_ack;
    assign wdata   = dsp_req ? dsp_data : cpu_data;

    // A period write restarts the divider, so no tick may escape in that cycle.
    assign tick = enable & ~per_wr & (cnt == '0);
    assign pop  = tick & ~fifo_empty;

    // Never shorter than one full 7-bit PWM cycle.
    assign per_clamped = (per_data < MIN_PER) ? MIN_PER : per_data;

    always_ff @(posedge XCK or negedge RESETL) begin
        if (!RESETL) begin
            period <= RST_PER;
            cnt    <= RST_PER - DIV_W'(1);
        end else if (per_wr) begin
            period <= per_clamped;
            cnt    <= per_clamped - DIV_W'(1);
        end else if (!enable || cnt == '0) begin
            cnt    <= period - DIV_W'(1);
        end else begin
            cnt    <= cnt - DIV_W'(1);
        end
    end

    always_ff @(posedge XCK) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge XCK or negedge RESETL) begin
        if (!RESETL) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge XCK or negedge RESETL) begin
        if (!RESETL) begin
            DACWRL   <= 1'b1;
            DAC_D    <= 16'h0000;
            underrun <= 1'b0;
        end else begin
            DACWRL <= ~pop;
            if (pop) begin
                DAC_D <= mem[rptr];
            end
            if (tick && fifo_empty) begin
                underrun <= 1'b1;
            end else if (clr_urun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_sched.sv
// tb/tb_dac_sample_sched.sv - directed table and sequence bench for dac_sample_sched
module tb_dac_sample_sched;

    logic        XCK;
    logic        RESETL;
    logic        dsp_req;
    logic [15:0] dsp_data;
    logic        dsp_ack;
    logic        cpu_req;
    logic [15:0] cpu_data;
    logic        cpu_ack;
    logic        per_wr;
    logic [11:0] per_data;
    logic        enable;
    logic        clr_urun;
    logic        DACWRL;
    logic [15:0] DAC_D;
    logic        fifo_full;
    logic        fifo_empty;
    logic [2:0]  fifo_level;
    logic        underrun;

    dac_sample_sched #(.DEPTH(4), .DIV_W(12)) dut (
        .XCK(XCK), .RESETL(RESETL),
        .dsp_req(dsp_req), .dsp_data(dsp_data), .dsp_ack(dsp_ack),
        .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .per_wr(per_wr), .per_data(per_data), .enable(enable), .clr_urun(clr_urun),
        .DACWRL(DACWRL), .DAC_D(DAC_D), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_level(fifo_level), .underrun(underrun)
    );

    initial XCK = 1'b0;
    always #5 XCK = ~XCK;

    int cyc = 0;
    always @(posedge XCK) cyc <= cyc + 1;

    // Strobe log: cycle index and word of every DAC load seen.
    int          sq[$];
    logic [15:0] dq[$];
    always @(negedge XCK) begin
        if (RESETL && !DACWRL) begin
            sq.push_back(cyc);
            dq.push_back(DAC_D);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge XCK);
        #1;
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) step();
    endtask

    function automatic int sq_at(input int i);
        return (i < sq.size()) ? sq[i] : -1;
    endfunction

    function automatic logic [15:0] dq_at(input int i);
        return (i < dq.size()) ? dq[i] : 16'hxxxx;
    endfunction

    typedef struct {
        logic        dreq;
        logic [15:0] ddata;
        logic        creq;
        logic [15:0] cdata;
        logic        exp_dack;
        logic        exp_cack;
        int          exp_level;
        logic        exp_full;
    } vec_t;

    vec_t vecs[6];

    int c, e, p1, q, ev, ack_cyc, lim;
    logic [15:0] play_exp[5];

    initial begin
        vecs[0] = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0};
        vecs[1] = '{1'b1, 16'hA001, 1'b1, 16'hC001, 1'b1, 1'b0, 2, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'hC001, 1'b0, 1'b1, 3, 1'b0};
        vecs[3] = '{1'b1, 16'hA002, 1'b1, 16'hC002, 1'b1, 1'b0, 4, 1'b1};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 16'hC002, 1'b0, 1'b0, 4, 1'b1};
        vecs[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 4, 1'b1};
        play_exp = '{16'h1234, 16'hA001, 16'hC001, 16'hA002, 16'hC002};

        RESETL = 1'b0; dsp_req = 0; dsp_data = 0; cpu_req = 0; cpu_data = 0;
        per_wr = 0; per_data = 0; enable = 0; clr_urun = 0;
        repeat (3) step();
        check("rst_dacwrl", DACWRL, 1'b1);
        check("rst_dac_d", DAC_D, 16'h0000);
        check("rst_empty", fifo_empty, 1'b1);
        check("rst_full", fifo_full, 1'b0);
        check("rst_level", fifo_level, 0);
        check("rst_underrun", underrun, 1'b0);

        // Reset period 512; push lands exactly on the first tick with FIFO empty.
        RESETL = 1'b1; enable = 1'b1; c = cyc;
        goto_cyc(c + 511);
        dsp_req = 1'b1; dsp_data = 16'hBEEF;
        #1 check("coinc_dsp_ack", dsp_ack, 1'b1);
        step(); dsp_req = 1'b0;
        check("coinc_underrun", underrun, 1'b1);
        check("coinc_level", fifo_level, 1);
        check("coinc_no_strobe", sq.size(), 0);
        goto_cyc(c + 1025);
        check("coinc_strobe_cyc", sq_at(0), c + 1024);
        check("coinc_word", dq_at(0), 16'hBEEF);
        clr_urun = 1'b1; step(); clr_urun = 1'b0;
        check("clr_underrun", underrun, 1'b0);

        // Period 128 while paused, then table-driven arbitration fill.
        enable = 1'b0; per_wr = 1'b1; per_data = 12'd128;
        step(); per_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dsp_req = vecs[i].dreq; dsp_data = vecs[i].ddata;
            cpu_req = vecs[i].creq; cpu_data = vecs[i].cdata;
            #1;
            check($sformatf("vec%0d_dsp_ack", i), dsp_ack, vecs[i].exp_dack);
            check($sformatf("vec%0d_cpu_ack", i), cpu_ack, vecs[i].exp_cack);
            step();
            check($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_level);
            check($sformatf("vec%0d_full", i), fifo_full, vecs[i].exp_full);
        end
        dsp_req = 1'b0;

        // CPU held against a full FIFO; granted in the cycle after the popping tick.
        cpu_req = 1'b1; cpu_data = 16'hC002; enable = 1'b1; e = cyc;
        ack_cyc = -1; lim = cyc + 300;
        while (cyc < lim && ack_cyc < 0) begin
            step();
            if (cpu_ack) begin
                ack_cyc = cyc;
                check("full_ack_level", fifo_level, 3);
                check("first_strobe_low", DACWRL, 1'b0);
                check("first_strobe_word", DAC_D, 16'h1234);
            end
        end
        check("full_cpu_ack_cyc", ack_cyc, e + 128);
        step(); cpu_req = 1'b0;
        check("full_refill_level", fifo_level, 4);
        check("full_refill_full", fifo_full, 1'b1);
        check("strobe_one_cycle", DACWRL, 1'b1);

        goto_cyc(e + 645);
        check("drain_count", sq.size(), 6);
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("drain%0d_cyc", i), sq_at(i), e + 128 * i);
            check($sformatf("drain%0d_word", i), dq_at(i), play_exp[i-1]);
        end

        // Underrun after drain, then set-wins-over-clear.
        goto_cyc(e + 767);
        check("pre_urun", underrun, 1'b0);
        step();
        check("urun_set", underrun, 1'b1);
        check("urun_no_strobe", DACWRL, 1'b1);
        check("urun_hold_word", DAC_D, 16'hC002);
        clr_urun = 1'b1; step();
        check("urun_cleared", underrun, 1'b0);
        goto_cyc(e + 896);
        check("urun_set_wins", underrun, 1'b1);
        step();
        check("urun_clear_after", underrun, 1'b0);
        clr_urun = 1'b0;
        check("urun_strobe_count", sq.size(), 6);

        // Period writes: 300, then 20 clamped to 128.
        per_wr = 1'b1; per_data = 12'd300; step(); per_wr = 1'b0;
        dsp_req = 1'b1; dsp_data = 16'h5A5A; step(); dsp_req = 1'b0;
        cpu_req = 1'b1; cpu_data = 16'h0A0B; step(); cpu_req = 1'b0;
        per_wr = 1'b1; per_data = 12'd20; p1 = cyc; step(); per_wr = 1'b0;
        goto_cyc(p1 + 262);
        check("clamp_count", sq.size(), 8);
        check("clamp_strobe0_cyc", sq_at(6), p1 + 129);
        check("clamp_strobe1_cyc", sq_at(7), p1 + 257);
        check("clamp_word0", dq_at(6), 16'h5A5A);
        check("clamp_word1", dq_at(7), 16'h0A0B);

        // Paused with two words queued, then re-enable and reset mid-strobe.
        enable = 1'b0; q = sq.size();
        dsp_req = 1'b1; dsp_data = 16'h7F80; step();
        dsp_data = 16'h8001; step(); dsp_req = 1'b0;
        repeat (1000) step();
        check("pause_no_strobe", sq.size(), q);
        check("pause_level", fifo_level, 2);
        enable = 1'b1; ev = cyc;
        goto_cyc(ev + 127);
        check("reen_early", DACWRL, 1'b1);
        goto_cyc(ev + 128);
        check("reen_strobe", DACWRL, 1'b0);
        check("reen_word0", DAC_D, 16'h7F80);
        goto_cyc(ev + 256);
        check("reen_strobe2", DACWRL, 1'b0);
        check("reen_word1", DAC_D, 16'h8001);
        RESETL = 1'b0;
        #1;
        check("async_rst_dacwrl", DACWRL, 1'b1);
        check("async_rst_dac_d", DAC_D, 16'h0000);
        check("async_rst_level", fifo_level, 0);
        step(); RESETL = 1'b1; step();
        check("post_rst_empty", fifo_empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
